online_to_conv: RTL and testbench
=================================

ONLINE_TO_CONV -- requirements
Module: online_to_conv

Interface
REQ-001 The block SHALL have parameter N, default 8: number of signed digits per conversion (N >= 2).
REQ-002 The block SHALL have ports:
  clk  input  1  rising-edge clock
  rst_n  input  1  asynchronous active-low reset
  start  input  1  begin a new conversion (pulse)
  in_valid  input  1  in_digit carries a valid digit
  in_digit  input  signed_digit (plus, minus)  one radix-2 signed digit, MSB first
  in_ready  output  1  block accepts a digit this cycle
  busy  output  1  conversion in progress (RUN or DONE)
  out_valid  output  1  out_data holds a completed result
  out_ready  input  1  consumer takes out_data
  out_data  output  N+1  two's-complement result

Function
REQ-003 Digit value SHALL be {plus,minus}: 10 = +1, 01 = -1, 00 = 0; 11 SHALL be treated as 0.
REQ-004 out_data SHALL equal the signed integer sum of p_j*2^(N-j), j = 1..N, where p_1 is the first digit accepted; the value read as a fraction is out_data*2^-N.
REQ-005 Conversion SHALL be on-the-fly: registers Q and QM (N+1 bits each), no carry-propagate adder on the digit path.
REQ-006 On start, Q SHALL clear to all zeros, QM SHALL be set to all ones (-1), and the digit counter SHALL clear to 0.
REQ-007 Per accepted digit: +1 -> Q = {Q,1}, QM = {Q,0}; 0 -> Q = {Q,0}, QM = {QM,1}; -1 -> Q = {QM,1}, QM = {QM,0}; {X,b} means shift left one bit, append b, keep N+1 bits.
REQ-008 Invariant: after every update, QM = Q - 1 modulo 2^(N+1).
REQ-009 FSM states SHALL be IDLE, RUN and DONE.
REQ-010 IDLE: in_ready = 0, out_valid = 0, busy = 0; start -> RUN, with the REQ-006 clear applied at the same edge.
REQ-011 RUN: in_ready = 1, busy = 1; a digit SHALL be accepted exactly when in_valid and in_ready are both 1; in_valid low stalls with no state change.
REQ-012 On the N-th accepted digit, the FSM SHALL go to DONE at that edge; out_valid SHALL be asserted the next cycle, i.e. latency 1 cycle from the last digit.
REQ-013 DONE: out_valid = 1, in_ready = 0, busy = 1; out_data = Q, held stable until out_ready.
REQ-014 DONE with out_ready = 1 and start = 0 SHALL go to IDLE.
REQ-015 DONE with out_ready = 1 and start = 1 SHALL go to RUN and apply the REQ-006 clear; this supports back-to-back conversions.
REQ-016 start SHALL be ignored in RUN, and in DONE while out_ready = 0.
REQ-017 in_valid SHALL be ignored outside RUN; start and in_valid together in IDLE SHALL accept no digit.
REQ-018 out_data SHALL hold the last result in IDLE until the next start clears Q.
REQ-019 The digit counter SHALL be ceil(log2(N+1)) bits and SHALL NOT wrap within a conversion.

Reset
REQ-020 When rst_n = 0, the block SHALL asynchronously enter IDLE with Q = 0, QM = all ones, counter = 0, in_ready = 0, out_valid = 0, busy = 0 and out_data = 0.
REQ-021 Reset asserted mid-RUN or in DONE SHALL abort the conversion; the partial result SHALL be discarded and no out_valid pulse produced.
REQ-022 Reset release SHALL be synchronous to clk; the first start SHALL be honoured on the first rising edge after release.

Verification (N=4)
REQ-023 Digits +1,0,-1,+1 with in_valid held high -> Q after each digit 1,2,3,7; out_data = 5'b00111; out_valid 1 cycle after the 4th digit.
REQ-024 Digits -1,-1,-1,-1 -> out_data = 5'b10001 (-15); digits -1,+1,+1,+1 -> out_data = 5'b11111 (-1); digits 11,00,11,00 -> 5'b00000.
REQ-025 Stall test: in_valid toggled 1,0,0,1,1,0,1 with digits +1 each valid cycle -> 4 digits accepted, out_data = 5'b01111; Q unchanged in stall cycles.
REQ-026 out_ready held 0 for 5 cycles in DONE -> out_valid and out_data stable; start pulsed during the stall is ignored; out_ready = 1 -> IDLE next cycle.
REQ-027 DONE with out_ready = 1 and start = 1 -> RUN next cycle, Q = 0; second conversion +1,+1,+1,+1 -> 5'b01111.
REQ-028 rst_n pulsed low after 2 digits -> IDLE immediately, all outputs 0; a new start plus digits 0,0,0,+1 -> out_data = 5'b00001.

Source files
------------

// File: rtl/online_to_conv_if.sv
// Bundle of the online_to_conv control/data signals, plus debug taps of the FSM state and the Q/QM registers.
// Handshakes: a digit moves when in_valid && in_ready at a rising edge; a result moves when out_valid && out_ready at a rising edge.
interface online_to_conv_if #(
  parameter int N = 8
) ();
  logic         start;
  logic         in_valid;
  logic [1:0]   in_digit;
  logic         in_ready;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_data;
  logic [1:0]   dbg_state;
  logic [N:0]   dbg_q;
  logic [N:0]   dbg_qm;

  modport master (
    output start, in_valid, in_digit, out_ready,
    input  in_ready, busy, out_valid, out_data, dbg_state, dbg_q, dbg_qm
  );

  modport slave (
    input  start, in_valid, in_digit, out_ready,
    output in_ready, busy, out_valid, out_data, dbg_state, dbg_q, dbg_qm
  );
endinterface

// File: rtl/online_to_conv.sv
// On-the-fly conversion of N radix-2 signed digits (MSB first) into an (N+1)-bit two's-complement value.
// Q and QM = Q-1 are kept side by side, so each digit is a shift-and-select with no carry chain.
module online_to_conv #(
  parameter int N = 8
) (
  input logic              clk,
  input logic              rst_n,
  online_to_conv_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N:0]    q, q_n, qm, qm_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          is_pos, is_neg;
  logic          in_ready_c, busy_c, out_valid_c;

  // Digit encoding {plus,minus}; the illegal 11 collapses to zero.
  assign is_pos = bus.in_digit[1] & ~bus.in_digit[0];
  assign is_neg = bus.in_digit[0] & ~bus.in_digit[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      q     <= '0;
      qm    <= '1;
      cnt   <= '0;
    end else begin
      state <= state_n;
      q     <= q_n;
      qm    <= qm_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    qm_n        = qm;
    cnt_n       = cnt;
    in_ready_c  = 1'b0;
    busy_c      = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = RUN;
          q_n     = '0;
          qm_n    = '1;
          cnt_n   = '0;
        end
      end
      RUN: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.in_valid) begin
          if (is_pos) begin
            q_n  = {q[N-1:0], 1'b1};
            qm_n = {q[N-1:0], 1'b0};
          end else if (is_neg) begin
            q_n  = {qm[N-1:0], 1'b1};
            qm_n = {qm[N-1:0], 1'b0};
          end else begin
            q_n  = {q[N-1:0], 1'b0};
            qm_n = {qm[N-1:0], 1'b1};
          end
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(N - 1)) state_n = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        busy_c      = 1'b1;
        // A start coinciding with the result handoff chains straight into the next conversion.
        if (bus.out_ready) begin
          if (bus.start) begin
            state_n = RUN;
            q_n     = '0;
            qm_n    = '1;
            cnt_n   = '0;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_data  = q;
  assign bus.dbg_state = state;
  assign bus.dbg_q     = q;
  assign bus.dbg_qm    = qm;
endmodule

// File: tb/tb_online_to_conv.sv
// Directed bench for online_to_conv (N=4): expected results queued by the driver, popped by a monitor on each handshake.
module tb_online_to_conv;
  localparam int N = 4;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] M = 2'b01;
  localparam logic [1:0] Z = 2'b00;
  localparam logic [1:0] X = 2'b11;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [N:0] exp_q[$];

  online_to_conv_if #(.N(N)) bus ();

  online_to_conv #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic send4(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c, input logic [1:0] d);
    logic [1:0] ds [4];
    ds[0] = a; ds[1] = b; ds[2] = c; ds[3] = d;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_digit = ds[i];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_digit = Z;
  endtask

  // scoreboard monitor
  logic       prev_hold;
  logic [N:0] prev_data;
  logic [N:0] exp_qm;
  logic [N:0] exp_res;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      exp_qm = bus.dbg_q - 5'd1;
      check("qm_invariant", 32'(bus.dbg_qm), 32'(exp_qm));
      if (prev_hold) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'(bus.out_data), 32'hffff_ffff);
        end else begin
          exp_res = exp_q.pop_front();
          check("result", 32'(bus.out_data), 32'(exp_res));
        end
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
    end
  end

  logic [N:0] model_q;
  logic       stall_pat [7];

  initial begin
    n_vec        = 0;
    n_err        = 0;
    prev_hold    = 1'b0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_digit = Z;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_qm", 32'(bus.dbg_qm), 32'h1f);
    rst_n = 1'b1;

    // +1,0,-1,+1 with per-digit Q trace
    exp_q.push_back(5'b00111);
    pulse_start();
    check("t1_state_run", 32'(bus.dbg_state), 32'(S_RUN));
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_digit = P; tick(); check("t1_q1", 32'(bus.dbg_q), 32'd1);
    bus.in_digit = Z; tick(); check("t1_q2", 32'(bus.dbg_q), 32'd2);
    bus.in_digit = M; tick(); check("t1_q3", 32'(bus.dbg_q), 32'd3);
    check("t1_no_valid_early", 32'(bus.out_valid), 32'd0);
    bus.in_digit = P; tick(); check("t1_q4", 32'(bus.dbg_q), 32'd7);
    bus.in_valid = 1'b0;
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_done_in_ready", 32'(bus.in_ready), 32'd0);
    check("t1_done_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t1_idle", 32'(bus.dbg_state), 32'(S_IDLE));
    check("t1_idle_busy", 32'(bus.busy), 32'd0);
    check("t1_idle_hold", 32'(bus.out_data), 32'h07);

    // start with in_valid in IDLE takes no digit; then -1 x4
    exp_q.push_back(5'b10001);
    bus.in_valid = 1'b1;
    bus.in_digit = P;
    pulse_start();
    bus.in_valid = 1'b0;
    check("t2_idle_no_digit", 32'(bus.dbg_q), 32'd0);
    send4(M, M, M, M);
    tick();

    exp_q.push_back(5'b11111);
    pulse_start();
    send4(M, P, P, P);
    tick();

    exp_q.push_back(5'b00000);
    pulse_start();
    send4(X, Z, X, Z);
    tick();

    // stall pattern with +1 digits
    exp_q.push_back(5'b01111);
    stall_pat[0] = 1; stall_pat[1] = 0; stall_pat[2] = 0; stall_pat[3] = 1;
    stall_pat[4] = 1; stall_pat[5] = 0; stall_pat[6] = 1;
    pulse_start();
    model_q = '0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = stall_pat[i];
      bus.in_digit = P;
      tick();
      if (stall_pat[i]) model_q = {model_q[N-1:0], 1'b1};
      check("t5_stall_q", 32'(bus.dbg_q), 32'(model_q));
    end
    bus.in_valid = 1'b0;
    check("t5_done", 32'(bus.dbg_state), 32'(S_DONE));
    tick();

    // DONE held with out_ready low; start and in_valid ignored
    exp_q.push_back(5'b01000);
    pulse_start();
    bus.out_ready = 1'b0;
    send4(P, Z, Z, Z);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_digit = P;
      bus.start    = (i == 2);
      tick();
      check("t6_stay_done", 32'(bus.dbg_state), 32'(S_DONE));
      check("t6_q_held", 32'(bus.dbg_q), 32'h08);
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("t6_idle", 32'(bus.dbg_state), 32'(S_IDLE));

    // back-to-back: start during DONE handoff
    exp_q.push_back(5'b00100);
    exp_q.push_back(5'b01111);
    pulse_start();
    send4(Z, P, Z, Z);
    pulse_start();
    check("t7_rerun", 32'(bus.dbg_state), 32'(S_RUN));
    check("t7_q_clear", 32'(bus.dbg_q), 32'd0);
    send4(P, P, P, P);
    tick();

    // reset mid-run discards the partial result
    pulse_start();
    bus.in_valid = 1'b1;
    bus.in_digit = P; tick();
    bus.in_digit = P; tick();
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t8_rst_state", 32'(bus.dbg_state), 32'(S_IDLE));
    check("t8_rst_busy", 32'(bus.busy), 32'd0);
    check("t8_rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("t8_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t8_rst_out_data", 32'(bus.out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    exp_q.push_back(5'b00001);
    pulse_start();
    check("t8_first_start", 32'(bus.dbg_state), 32'(S_RUN));
    send4(Z, Z, Z, P);
    tick();

    repeat (3) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
